// File: rtl/pid_seq_pkg.sv
// Shared types and constants for the PID/CORDIC loop sequencer.
// Holds the FSM state enum, default widths, clip bounds and the minimum period.
package pid_seq_pkg;

    localparam int DATA_W_DEF   = 12;
    localparam int PID_W_DEF    = 17;
    localparam int PERIOD_W_DEF = 16;
    localparam int TIMEOUT_DEF  = 255;

    localparam int MIN_PERIOD   = 4;

    // Signed clip bounds for a w-bit two's complement result
    function automatic int sat_max(int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(int w);
        return -(1 << (w - 1));
    endfunction

    localparam int SAT_MAX = sat_max(DATA_W_DEF);
    localparam int SAT_MIN = sat_min(DATA_W_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PID_RUN = 2'd1,
        COR_RUN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sample_timer.sv
// Programmable down-counter issuing one tick per sample period while enabled.
// Ports: PCLK/PRESETn clock+reset, en gate, period (<4 acts as 4), tick out.
module sample_timer
    import pid_seq_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] reload;
    logic [PERIOD_W-1:0] cur;
    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic                armed_q;
    logic                armed_d;

    always_comb begin
        if (period < PERIOD_W'(MIN_PERIOD)) begin
            reload = PERIOD_W'(MIN_PERIOD - 1);
        end else begin
            reload = period - PERIOD_W'(1);
        end
    end

    // While not armed (after reset or with en low) the effective count is
    // the live reload value, so the counter never needs a data-dependent
    // reset value.
    assign cur  = armed_q ? cnt_q : reload;
    assign tick = en && (cur == '0);

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = 1'b0;
        if (en) begin
            armed_d = 1'b1;
            cnt_d   = tick ? reload : cur - PERIOD_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/pid_loop_sequencer.sv
// Closed-loop scheduler: per tick runs PID(target,y) -> clip -> CORDIC, publishes result.
// Ports: timer config (en, period), operands, PID/CORDIC handshakes, ctrl out, sticky flags.
module pid_loop_sequencer
    import pid_seq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PID_W    = PID_W_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic [DATA_W-1:0]   target,
    input  logic [DATA_W-1:0]   y_meas,
    input  logic                err_clr,
    output logic                pid_start,
    output logic [DATA_W-1:0]   pid_target,
    output logic [DATA_W-1:0]   pid_y,
    input  logic                pid_done,
    input  logic [PID_W-1:0]    pid_result,
    output logic                cordic_start,
    output logic [DATA_W-1:0]   cordic_in,
    input  logic                cordic_done,
    input  logic [DATA_W-1:0]   cordic_result,
    output logic [DATA_W-1:0]   ctrl_out,
    output logic                ctrl_valid,
    output logic                busy,
    output logic                sat_flag,
    output logic                overrun,
    output logic                timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic signed [PID_W-1:0] P_MAX = PID_W'(sat_max(DATA_W));
    localparam logic signed [PID_W-1:0] P_MIN = PID_W'(sat_min(DATA_W));

    logic tick;

    sample_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      (en),
        .period  (period),
        .tick    (tick)
    );

    logic signed [PID_W-1:0] pid_s;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [DATA_W-1:0]       sat_val;

    assign pid_s = $signed(pid_result);

    always_comb begin
        sat_hi  = pid_s > P_MAX;
        sat_lo  = pid_s < P_MIN;
        sat_val = pid_result[DATA_W-1:0];
        if (sat_hi) begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sat_lo) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    seq_state_e        state_q;
    logic [TW-1:0]     tmo_q;
    logic              pid_start_q;
    logic              cordic_start_q;
    logic              ctrl_valid_q;
    logic [DATA_W-1:0] pid_target_q;
    logic [DATA_W-1:0] pid_y_q;
    logic [DATA_W-1:0] cordic_in_q;
    logic [DATA_W-1:0] ctrl_out_q;
    logic              sat_q;
    logic              ovr_q;
    logic              tmo_err_q;

    // Flag clears are written before the set events so a coincident set wins.
    // A done in the start cycle is ignored; done on the expiry cycle wins.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q        <= IDLE;
            tmo_q          <= '0;
            pid_start_q    <= 1'b0;
            cordic_start_q <= 1'b0;
            ctrl_valid_q   <= 1'b0;
            pid_target_q   <= '0;
            pid_y_q        <= '0;
            cordic_in_q    <= '0;
            ctrl_out_q     <= '0;
            sat_q          <= 1'b0;
            ovr_q          <= 1'b0;
            tmo_err_q      <= 1'b0;
        end else begin
            pid_start_q    <= 1'b0;
            cordic_start_q <= 1'b0;
            ctrl_valid_q   <= 1'b0;
            if (err_clr) begin
                sat_q     <= 1'b0;
                ovr_q     <= 1'b0;
                tmo_err_q <= 1'b0;
            end
            if (tick && state_q != IDLE) begin
                ovr_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (tick) begin
                        pid_target_q <= target;
                        pid_y_q      <= y_meas;
                        pid_start_q  <= 1'b1;
                        tmo_q        <= '0;
                        state_q      <= PID_RUN;
                    end
                end
                PID_RUN: begin
                    if (pid_done && !pid_start_q) begin
                        cordic_in_q    <= sat_val;
                        cordic_start_q <= 1'b1;
                        tmo_q          <= '0;
                        state_q        <= COR_RUN;
                        if (sat_hi || sat_lo) begin
                            sat_q <= 1'b1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                COR_RUN: begin
                    if (cordic_done && !cordic_start_q) begin
                        ctrl_out_q   <= cordic_result;
                        ctrl_valid_q <= 1'b1;
                        state_q      <= IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pid_start    = pid_start_q;
    assign cordic_start = cordic_start_q;
    assign ctrl_valid   = ctrl_valid_q;
    assign pid_target   = pid_target_q;
    assign pid_y        = pid_y_q;
    assign cordic_in    = cordic_in_q;
    assign ctrl_out     = ctrl_out_q;
    assign busy         = (state_q != IDLE);
    assign sat_flag     = sat_q;
    assign overrun      = ovr_q;
    assign timeout_err  = tmo_err_q;

endmodule
